// File: rtl/input_event_arbiter_if.sv
// Event output stream between the arbiter FIFO head and the beep consumer.
//   evt_valid  head-of-queue event present
//   evt_src    0=UART 1=IR 2=PS2
//   evt_code   event byte
//   evt_ready  consumer accepts head when evt_valid & evt_ready
interface input_event_arbiter_if;
  logic       evt_valid;
  logic [1:0] evt_src;
  logic [7:0] evt_code;
  logic       evt_ready;

  modport master (output evt_valid, evt_src, evt_code, input evt_ready);
  modport slave  (input evt_valid, evt_src, evt_code, output evt_ready);
endinterface

// File: rtl/input_event_arbiter.sv
// Merges UART, IR and PS/2 completion pulses into one ordered event FIFO.
// Each source has a one-entry pending slot; a fixed-priority arbiter
// (UART > IR > PS2) moves at most one slot per cycle into a first-word
// fall-through FIFO that is read over a valid/ready handshake.
// Ports:
//   CLK_50M, RST_N        clock, synchronous active-low reset
//   uart_finish/in_rx_data  UART byte strobe + data
//   ir_finish/in_ir_data    IR command strobe + data
//   ps2_finish/in_ps2_data  PS/2 word strobe + {prefix, scancode}
//   evt                     event stream (master side)
//   fifo_level              entries queued, 0..DEPTH
//   ovf / clr_ovf           sticky arrival-loss flag and its clear
module input_event_arbiter #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned DROP_PS2_BREAK = 1
) (
  input  logic                        CLK_50M,
  input  logic                        RST_N,
  input  logic                        uart_finish,
  input  logic [7:0]                  in_rx_data,
  input  logic                        ir_finish,
  input  logic [7:0]                  in_ir_data,
  input  logic                        ps2_finish,
  input  logic [15:0]                 in_ps2_data,
  input_event_arbiter_if.master       evt,
  output logic [ADDR_W:0]             fifo_level,
  output logic                        ovf,
  input  logic                        clr_ovf
);

  localparam int unsigned NSRC  = 3;
  localparam int unsigned LVL_W = ADDR_W + 1;

  logic [NSRC-1:0]   slot_full;
  logic [7:0]        slot_code [NSRC];
  logic [1:0]        src_mem   [DEPTH];
  logic [7:0]        code_mem  [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              valid_q;

  logic              ps2_break_c;
  logic [NSRC-1:0]   pulse_c;
  logic [7:0]        in_code_c [NSRC];
  logic              pop_c;
  logic              can_push_c;
  logic [NSRC-1:0]   grant_c;
  logic              push_c;
  logic [1:0]        grant_src_c;
  logic [7:0]        grant_code_c;
  logic [NSRC-1:0]   keep_c;
  logic              loss_c;
  logic [LVL_W-1:0]  level_next_c;
  logic [ADDR_W-1:0] head_idx_c;

  // Arrival qualification, priority grant and FIFO bookkeeping
  always_comb begin
    ps2_break_c  = (DROP_PS2_BREAK != 0) && (in_ps2_data[15:8] == 8'hF0);
    pulse_c      = {ps2_finish & ~ps2_break_c, ir_finish, uart_finish};
    in_code_c[0] = in_rx_data;
    in_code_c[1] = in_ir_data;
    in_code_c[2] = in_ps2_data[7:0];

    pop_c      = valid_q & evt.evt_ready;
    can_push_c = (fifo_level != LVL_W'(DEPTH)) | pop_c;

    grant_c      = '0;
    grant_src_c  = 2'd0;
    grant_code_c = slot_code[0];
    if (can_push_c) begin
      if (slot_full[0]) begin
        grant_c[0]   = 1'b1;
      end else if (slot_full[1]) begin
        grant_c[1]   = 1'b1;
        grant_src_c  = 2'd1;
        grant_code_c = slot_code[1];
      end else if (slot_full[2]) begin
        grant_c[2]   = 1'b1;
        grant_src_c  = 2'd2;
        grant_code_c = slot_code[2];
      end
    end
    push_c = |grant_c;

    // A full slot keeps its data unless it drains this same cycle
    keep_c = slot_full & ~grant_c;
    loss_c = |(pulse_c & keep_c);

    unique case ({push_c, pop_c})
      2'b10:   level_next_c = fifo_level + LVL_W'(1);
      2'b01:   level_next_c = fifo_level - LVL_W'(1);
      default: level_next_c = fifo_level;
    endcase

    // When empty, keep showing the entry popped last so outputs hold
    head_idx_c = valid_q ? rd_ptr : rd_ptr - ADDR_W'(1);
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_src   = src_mem[head_idx_c];
  assign evt.evt_code  = code_mem[head_idx_c];

  // Slots, FIFO storage, pointers, level and overflow flag
  always_ff @(posedge CLK_50M) begin
    if (!RST_N) begin
      slot_full  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      valid_q    <= 1'b0;
      fifo_level <= '0;
      ovf        <= 1'b0;
      for (int unsigned s = 0; s < NSRC; s++) slot_code[s] <= 8'h00;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        src_mem[i]  <= 2'd0;
        code_mem[i] <= 8'h00;
      end
    end else begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        if (pulse_c[s] && !keep_c[s]) begin
          slot_full[s] <= 1'b1;
          slot_code[s] <= in_code_c[s];
        end else if (grant_c[s]) begin
          slot_full[s] <= 1'b0;
        end
      end
      if (push_c) begin
        src_mem[wr_ptr]  <= grant_src_c;
        code_mem[wr_ptr] <= grant_code_c;
        wr_ptr           <= wr_ptr + ADDR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + ADDR_W'(1);
      fifo_level <= level_next_c;
      valid_q    <= (level_next_c != '0);
      if (loss_c)       ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_event_arbiter.sv
// Scoreboard bench for input_event_arbiter: directed scenarios followed by
// random traffic, checked against a queue-based behavioural model.
module tb_input_event_arbiter;

  localparam int DEPTH = 8;

  logic        CLK_50M = 1'b0;
  logic        RST_N;
  logic        uart_finish, ir_finish, ps2_finish, clr_ovf;
  logic [7:0]  in_rx_data, in_ir_data;
  logic [15:0] in_ps2_data;
  logic [3:0]  fifo_level;
  logic        ovf;

  input_event_arbiter_if bus ();

  input_event_arbiter #(.DEPTH(8), .ADDR_W(3), .DROP_PS2_BREAK(1)) dut (
    .CLK_50M    (CLK_50M),
    .RST_N      (RST_N),
    .uart_finish(uart_finish),
    .in_rx_data (in_rx_data),
    .ir_finish  (ir_finish),
    .in_ir_data (in_ir_data),
    .ps2_finish (ps2_finish),
    .in_ps2_data(in_ps2_data),
    .evt        (bus),
    .fifo_level (fifo_level),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf)
  );

  always #10 CLK_50M = ~CLK_50M;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: pending slots, queued count, sticky loss flag
  bit       m_full [3];
  bit [7:0] m_code [3];
  int       m_level;
  bit       m_ovf;
  logic [9:0] exp_q [$];  // {src, code} in expected pop order

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of inputs (called just after a rising edge), advance the
  // model across the next edge, then compare the visible state.
  task automatic step(input bit u, input logic [7:0] ud, input bit ir,
                      input logic [7:0] id, input bit p, input logic [15:0] pd,
                      input bit rdy, input bit clr, input bit rst);
    bit       n_full [3];
    bit [7:0] n_code [3];
    bit       v [3];
    logic [7:0] d [3];
    int  n_level, g;
    bit  n_ovf, pop, can, loss;

    uart_finish = u;  in_rx_data  = ud;
    ir_finish   = ir; in_ir_data  = id;
    ps2_finish  = p;  in_ps2_data = pd;
    bus.evt_ready = rdy; clr_ovf = clr; RST_N = ~rst;

    if (rst) begin
      n_full = '{0, 0, 0}; n_code = '{0, 0, 0};
      n_level = 0; n_ovf = 0;
      exp_q.delete();
    end else begin
      n_full = m_full; n_code = m_code;
      pop = (m_level != 0) && rdy;
      can = (m_level < DEPTH) || pop;
      g = -1;
      for (int s = 0; s < 3; s++)
        if (g < 0 && m_full[s] && can) g = s;
      if (g >= 0) begin
        exp_q.push_back({2'(g), m_code[g]});
        n_full[g] = 0;
      end
      n_level = m_level + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
      v[0] = u; v[1] = ir; v[2] = p && (pd[15:8] != 8'hF0);
      d[0] = ud; d[1] = id; d[2] = pd[7:0];
      loss = 0;
      for (int s = 0; s < 3; s++) begin
        if (v[s]) begin
          if (m_full[s] && g != s) loss = 1;
          else begin n_full[s] = 1; n_code[s] = d[s]; end
        end
      end
      n_ovf = loss ? 1'b1 : (clr ? 1'b0 : m_ovf);
    end

    @(posedge CLK_50M); #1;
    m_full = n_full; m_code = n_code; m_level = n_level; m_ovf = n_ovf;
    check("evt_valid", int'(bus.evt_valid), (m_level != 0) ? 1 : 0);
    check("fifo_level", int'(fifo_level), m_level);
    check("ovf", int'(ovf), int'(m_ovf));
  endtask

  task automatic idle(input bit rdy);
    step(0, 8'h00, 0, 8'h00, 0, 16'h0000, rdy, 0, 0);
  endtask

  task automatic uart(input logic [7:0] b, input bit rdy);
    step(1, b, 0, 8'h00, 0, 16'h0000, rdy, 0, 0);
  endtask

  // Monitor: every accepted event must match the scoreboard head
  always @(negedge CLK_50M) begin
    logic [9:0] e;
    if (RST_N === 1'b1 && bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got src %0d code %0h with no event expected at %0t",
                 bus.evt_src, bus.evt_code, $time);
      end else begin
        e = exp_q.pop_front();
        check("evt_src", int'(bus.evt_src), int'(e[9:8]));
        check("evt_code", int'(bus.evt_code), int'(e[7:0]));
      end
    end
  end

  initial begin
    int rdy_pct;
    bit [7:0] pre;
    RST_N = 0; uart_finish = 0; ir_finish = 0; ps2_finish = 0; clr_ovf = 0;
    in_rx_data = 0; in_ir_data = 0; in_ps2_data = 0; bus.evt_ready = 0;
    m_full = '{0, 0, 0}; m_code = '{0, 0, 0}; m_level = 0; m_ovf = 0;
    repeat (2) @(posedge CLK_50M);
    #1;
    check("reset_valid", int'(bus.evt_valid), 0);
    check("reset_level", int'(fifo_level), 0);
    check("reset_ovf", int'(ovf), 0);
    check("reset_src", int'(bus.evt_src), 0);
    check("reset_code", int'(bus.evt_code), 0);

    // Single event latency
    uart(8'h41, 0);
    check("single_not_yet", int'(bus.evt_valid), 0);
    idle(0);
    check("single_valid", int'(bus.evt_valid), 1);
    check("single_src", int'(bus.evt_src), 0);
    check("single_code", int'(bus.evt_code), 'h41);
    idle(1);
    check("single_drained", int'(fifo_level), 0);

    // Simultaneous arrivals
    step(1, 8'h11, 1, 8'h22, 1, 16'h001C, 0, 0, 0);
    repeat (3) idle(0);
    check("simul_peak", int'(fifo_level), 3);
    check("simul_ovf", int'(ovf), 0);
    repeat (3) idle(1);

    // PS/2 break discard then make code
    step(0, 8'h00, 0, 8'h00, 1, 16'hF01C, 0, 0, 0);
    repeat (2) idle(0);
    check("break_dropped", int'(fifo_level), 0);
    step(0, 8'h00, 0, 8'h00, 1, 16'h001C, 0, 0, 0);
    idle(0);
    check("make_code", int'(bus.evt_code), 'h1C);
    idle(1);

    // Full FIFO backpressure and overflow
    for (int k = 0; k < 9; k++) begin
      uart(8'(k), 0);
      idle(0);
      idle(0);
    end
    check("full_level", int'(fifo_level), 8);
    check("full_no_ovf", int'(ovf), 0);
    uart(8'h09, 0);
    check("full_ovf", int'(ovf), 1);
    idle(1);
    check("pop_push_level", int'(fifo_level), 8);
    step(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0, 1, 0);
    check("ovf_cleared", int'(ovf), 0);
    repeat (8) idle(1);
    check("drained", int'(fifo_level), 0);

    // Reset mid-burst
    for (int k = 0; k < 5; k++) begin
      uart(8'h50 + 8'(k), 0);
      idle(0);
    end
    idle(0);
    check("burst_level", int'(fifo_level), 5);
    step(0, 8'h00, 0, 8'h00, 0, 16'h0000, 1, 0, 1);
    check("rst_src", int'(bus.evt_src), 0);
    check("rst_code", int'(bus.evt_code), 0);
    uart(8'h41, 0);
    idle(0);
    check("post_rst_code", int'(bus.evt_code), 'h41);
    idle(1);

    // Random traffic
    rdy_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) rdy_pct = $urandom_range(0, 100);
      pre = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom);
      step($urandom_range(0, 3) == 0, 8'($urandom),
           $urandom_range(0, 3) == 0, 8'($urandom),
           $urandom_range(0, 3) == 0, {pre, 8'($urandom)},
           $urandom_range(0, 99) < rdy_pct,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 499) == 0);
    end
    repeat (12) idle(1);
    check("final_empty", int'(fifo_level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
